// File: rtl/pipeline_control_unit_if.sv
// Pipeline control bus: ID-stage instruction/flush/flags in, EX/MEM/WB control and stall out.
// master = instruction fetch/branch side, slave = pipeline_control_unit.
interface pipeline_control_unit_if #(
    parameter int RD_W = 4
);
    logic [31:0]     instruction;
    logic            flush;
    logic [3:0]      flags;
    logic [3:0]      ex_alu_op;
    logic            ex_shift_imm;
    logic            ex_load;
    logic            ex_rf_en;
    logic            ex_b_instr;
    logic            mem_rw;
    logic [1:0]      mem_data_size;
    logic            mem_load;
    logic            mem_rf_en;
    logic [RD_W-1:0] mem_rd;
    logic            wb_rf_en;
    logic [RD_W-1:0] wb_rd;
    logic            stall;

    modport master (
        output instruction, flush, flags,
        input  ex_alu_op, ex_shift_imm, ex_load, ex_rf_en, ex_b_instr,
        input  mem_rw, mem_data_size, mem_load, mem_rf_en, mem_rd,
        input  wb_rf_en, wb_rd, stall
    );

    modport slave (
        input  instruction, flush, flags,
        output ex_alu_op, ex_shift_imm, ex_load, ex_rf_en, ex_b_instr,
        output mem_rw, mem_data_size, mem_load, mem_rf_en, mem_rd,
        output wb_rf_en, wb_rd, stall
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// ARM-style decode plus EX/MEM/WB control pipeline with load-use stall FSM and branch flush.
// Optional macro PCU_COND_EXEC_EN: squash instructions whose condition field fails against NZCV.
module pipeline_control_unit #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int RD_W             = 4
) (
    input logic                    clk,
    input logic                    reset_n,
    pipeline_control_unit_if.slave bus
);
    typedef struct packed {
        logic [3:0]      alu_op;
        logic            shift_imm;
        logic            load;
        logic            rf_en;
        logic            b_instr;
        logic            rw;
        logic [1:0]      data_size;
        logic [RD_W-1:0] rd;
    } ctl_t;

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

    logic [31:0] instr;
    logic        dp, ls, br, is_load, is_store, use_rm, hazard, cond_ok;
    ctl_t        id_ctl, ex_d, ex_q;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        bubble;

    logic            mem_rw_q, mem_load_q, mem_rf_en_q, wb_rf_en_q;
    logic [1:0]      mem_ds_q;
    logic [RD_W-1:0] mem_rd_q, wb_rd_q;

    assign instr    = bus.instruction;
    assign dp       = (instr[27:26] == 2'b00);
    assign ls       = (instr[27:26] == 2'b01);
    assign br       = (instr[27:25] == 3'b101);
    assign is_load  = ls & instr[20];
    assign is_store = ls & ~instr[20];

    always_comb begin
        id_ctl           = '0;
        id_ctl.alu_op    = instr[24:21];
        id_ctl.shift_imm = instr[25];
        id_ctl.load      = is_load;
        id_ctl.b_instr   = br;
        id_ctl.rw        = ~is_store;
        id_ctl.data_size = ls ? {1'b0, instr[22]} : 2'b00;
        // Compare/test opcodes (1000..1011) write no register; BL writes the link register.
        id_ctl.rf_en     = (dp & (instr[24:23] != 2'b10)) | is_load | (br & instr[24]);
        id_ctl.rd        = (br & instr[24]) ? RD_W'(14) : RD_W'(instr[15:12]);
    end

`ifdef PCU_COND_EXEC_EN
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = cy;
            4'h3:    cond_pass = ~cy;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = cy & ~z;
            4'h9:    cond_pass = ~cy | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = ~z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_pass(instr[31:28], bus.flags);
    logic unused_bits;
    assign unused_bits = ^instr[11:4];
`else
    assign cond_ok = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{instr[31:28], instr[11:4], bus.flags};
`endif

    // Rm is only a source register for stores and register-operand data processing.
    assign use_rm = is_store | (dp & ~instr[25]);
    assign hazard = ex_q.load & ex_q.rf_en &
                    ((ex_q.rd == RD_W'(instr[19:16])) | (use_rm & (ex_q.rd == RD_W'(instr[3:0]))));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        bus.stall = 1'b0;
        if (bus.flush) begin
            bubble  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (hazard) begin
                    bus.stall = 1'b1;
                    bubble    = 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = (CNT_INIT != 2'd0) ? STALL : IDLE;
                end
                // Counter holds the bubbles still owed; the one reaching zero ends the stall.
                STALL: begin
                    bus.stall = 1'b1;
                    bubble    = 1'b1;
                    if (cnt_q <= 2'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ex_d = id_ctl;
        if (bubble || !cond_ok) ex_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ex_q        <= '0;
            ex_q.rw     <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_ds_q    <= '0;
            mem_load_q  <= 1'b0;
            mem_rf_en_q <= 1'b0;
            mem_rd_q    <= '0;
            wb_rf_en_q  <= 1'b0;
            wb_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_q        <= ex_d;
            mem_rw_q    <= ex_q.rw;
            mem_ds_q    <= ex_q.data_size;
            mem_load_q  <= ex_q.load;
            mem_rf_en_q <= ex_q.rf_en;
            mem_rd_q    <= ex_q.rd;
            wb_rf_en_q  <= mem_rf_en_q;
            wb_rd_q     <= mem_rd_q;
        end
    end

    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_shift_imm  = ex_q.shift_imm;
    assign bus.ex_load       = ex_q.load;
    assign bus.ex_rf_en      = ex_q.rf_en;
    assign bus.ex_b_instr    = ex_q.b_instr;
    assign bus.mem_rw        = mem_rw_q;
    assign bus.mem_data_size = mem_ds_q;
    assign bus.mem_load      = mem_load_q;
    assign bus.mem_rf_en     = mem_rf_en_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.wb_rf_en      = wb_rf_en_q;
    assign bus.wb_rd         = wb_rd_q;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: two instances (1 and 3 load-use bubbles) on one stream,
// per-cycle comparison against a stage-history model plus directed literal checks.
module tb_pipeline_control_unit;
    localparam logic [31:0] NOP  = 32'hE1A00000;
    localparam logic [31:0] ADD  = 32'hE0812003;
    localparam logic [31:0] LDR  = 32'hE5912000;
    localparam logic [31:0] ADD2 = 32'hE0823003;
    localparam logic [31:0] STRB = 32'h05C12000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = NOP;
    logic        fl = 1'b0;
    logic [3:0]  flg = 4'b0000;
    int          cmp = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pipeline_control_unit_if #(.RD_W(4)) bus1 ();
    pipeline_control_unit_if #(.RD_W(4)) bus3 ();

    assign bus1.instruction = instr;
    assign bus1.flush       = fl;
    assign bus1.flags       = flg;
    assign bus3.instruction = instr;
    assign bus3.flush       = fl;
    assign bus3.flags       = flg;

    pipeline_control_unit #(.LOAD_USE_BUBBLES(1), .RD_W(4)) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));
    pipeline_control_unit #(.LOAD_USE_BUBBLES(3), .RD_W(4)) dut3 (.clk(clk), .reset_n(rst_n), .bus(bus3));

    wire [22:0] act1 = {bus1.ex_alu_op, bus1.ex_shift_imm, bus1.ex_load, bus1.ex_rf_en, bus1.ex_b_instr,
                        bus1.mem_rw, bus1.mem_data_size, bus1.mem_load, bus1.mem_rf_en, bus1.mem_rd,
                        bus1.wb_rf_en, bus1.wb_rd, bus1.stall};
    wire [22:0] act3 = {bus3.ex_alu_op, bus3.ex_shift_imm, bus3.ex_load, bus3.ex_rf_en, bus3.ex_b_instr,
                        bus3.mem_rw, bus3.mem_data_size, bus3.mem_load, bus3.mem_rf_en, bus3.mem_rd,
                        bus3.wb_rf_en, bus3.wb_rd, bus3.stall};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: stage history + owed-stall count ----------------
    typedef struct packed {
        logic [3:0] alu;
        logic       sh, ld, rf, b, rw;
        logic [1:0] ds;
        logic [3:0] rd;
    } mctl_t;

    mctl_t m_ex [2];
    mctl_t m_mem[2];
    mctl_t m_wb [2];
    int    left [2];
    int    lub  [2] = '{1, 3};

    function automatic mctl_t mdec(input logic [31:0] i);
        mctl_t c;
        bit dp, ls, br;
        dp = (i[27:26] == 2'b00);
        ls = (i[27:26] == 2'b01);
        br = (i[27:25] == 3'b101);
        c     = '0;
        c.alu = i[24:21];
        c.sh  = i[25];
        c.ld  = ls && i[20];
        c.b   = br;
        c.rw  = !(ls && !i[20]);
        c.ds  = ls ? {1'b0, i[22]} : 2'b00;
        c.rf  = (dp && !(i[24:21] >= 4'd8 && i[24:21] <= 4'd11)) || c.ld || (br && i[24]);
        c.rd  = (br && i[24]) ? 4'd14 : i[15:12];
        return c;
    endfunction

    function automatic bit m_exec(input logic [3:0] c, input logic [3:0] f);
`ifdef PCU_COND_EXEC_EN
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;           1: return !z;
            2: return cy;          3: return !cy;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return cy && !z;    9: return !cy || z;
            10: return n == v;     11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
`else
        return (c == c) && (f == f);
`endif
    endfunction

    function automatic bit m_haz(input int d);
        bit use_rm;
        use_rm = (instr[27:26] == 2'b01 && !instr[20]) || (instr[27:26] == 2'b00 && !instr[25]);
        return m_ex[d].ld && m_ex[d].rf &&
               (m_ex[d].rd == instr[19:16] || (use_rm && m_ex[d].rd == instr[3:0]));
    endfunction

    function automatic bit m_stall(input int d);
        if (!rst_n || fl) return 1'b0;
        if (left[d] > 0) return 1'b1;
        return m_haz(d);
    endfunction

    function automatic logic [22:0] m_vec(input int d);
        return {m_ex[d].alu, m_ex[d].sh, m_ex[d].ld, m_ex[d].rf, m_ex[d].b,
                m_mem[d].rw, m_mem[d].ds, m_mem[d].ld, m_mem[d].rf, m_mem[d].rd,
                m_wb[d].rf, m_wb[d].rd, m_stall(d)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_ex[d]     <= '{rw: 1'b1, default: '0};
                m_mem[d]    <= '{rw: 1'b1, default: '0};
                m_wb[d]     <= '0;
                left[d]     <= 0;
            end else begin
                m_wb[d]  <= m_mem[d];
                m_mem[d] <= m_ex[d];
                m_ex[d]  <= (fl || m_stall(d) || !m_exec(instr[31:28], flg)) ? mctl_t'(0) : mdec(instr);
                if (fl)               left[d] <= 0;
                else if (left[d] > 0) left[d] <= left[d] - 1;
                else if (m_haz(d))    left[d] <= lub[d] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cycle_lub1", 32'(act1), 32'(m_vec(0)));
            chk("cycle_lub3", 32'(act3), 32'(m_vec(1)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic [31:0] i, input logic f);
        instr = i;
        fl    = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #12;
        chk("reset_lub1", 32'(act1), 32'h4000);
        chk("reset_lub3", 32'(act3), 32'h4000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD r2,r1,r3 through the pipe
        set_in(ADD, 0); tick();
        chk("add_ex", 32'({bus1.ex_alu_op, bus1.ex_rf_en}), 32'h09);
        set_in(NOP, 0); tick();
        set_in(NOP, 0); tick();
        chk("add_wb", 32'({bus1.wb_rf_en, bus1.wb_rd}), 32'h12);

        // LDR r2 then ADD using r2
        set_in(LDR, 0); tick();
        set_in(ADD2, 0);
        chk("lu_stall_a", 32'({bus1.stall, bus3.stall}), 32'h3);
        tick(); #1;
        chk("lu_b_ex1", 32'({bus1.ex_alu_op, bus1.ex_rf_en, bus1.stall}), 32'h00);
        chk("lu_b_ex3", 32'({bus3.ex_alu_op, bus3.ex_rf_en, bus3.stall}), 32'h01);
        tick(); #1;
        chk("lu_c_ex1", 32'({bus1.ex_alu_op, bus1.ex_rf_en}), 32'h09);
        chk("lu_c_ex3", 32'({bus3.ex_alu_op, bus3.ex_rf_en, bus3.stall}), 32'h01);
        tick(); #1;
        chk("lu_d_ex3", 32'({bus3.ex_alu_op, bus3.ex_rf_en, bus3.stall}), 32'h00);
        tick(); #1;
        chk("lu_e_ex3", 32'({bus3.ex_alu_op, bus3.ex_rf_en}), 32'h09);
        set_in(NOP, 0); tick(); tick(); tick();

        // flush during the second stall cycle of the 3-bubble instance
        set_in(LDR, 0); tick();
        set_in(ADD2, 0); tick();
        set_in(ADD2, 1);
        chk("fl_stall3", 32'(bus3.stall), 32'h0);
        tick();
        set_in(ADD2, 0);
        chk("fl_ex3", 32'({bus3.ex_alu_op, bus3.ex_rf_en, bus3.stall}), 32'h00);
        tick(); #1;
        chk("fl_after3", 32'({bus3.ex_alu_op, bus3.ex_rf_en}), 32'h09);
        set_in(NOP, 0); tick(); tick(); tick();

        // STRBEQ with Z clear, then Z set
        flg = 4'b0000;
        set_in(STRB, 0); tick();
        set_in(NOP, 0); tick();
`ifdef PCU_COND_EXEC_EN
        chk("strb_z0", 32'({bus1.mem_rw, bus1.mem_data_size}), 32'h0);
`else
        chk("strb_z0", 32'({bus1.mem_rw, bus1.mem_data_size}), 32'h1);
`endif
        flg = 4'b0100;
        set_in(STRB, 0); tick();
        set_in(NOP, 0); tick();
        chk("strb_z1", 32'({bus1.mem_rw, bus1.mem_data_size}), 32'h1);
        flg = 4'b0000;
        tick(); tick();

        // asynchronous reset in the middle of a stall
        set_in(LDR, 0); tick();
        set_in(ADD2, 0);
        chk("rst_pre", 32'(bus3.stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid1", 32'(act1), 32'h4000);
        chk("rst_mid3", 32'(act3), 32'h4000);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick(); #1;
        chk("rst_rel3", 32'({bus3.ex_alu_op, bus3.ex_rf_en, bus3.stall}), 32'h12);
        set_in(NOP, 0); tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter LOAD_USE_BUBBLES, default 1, meaning the number of bubbles inserted on a load-use hazard (legal 1..3).
REQ-002 SHALL have parameter RD_W, default 4, meaning the register-index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port instruction, input, 32, the ARM instruction in ID.
REQ-006 SHALL have port flush, input, 1, meaning branch taken: squash ID and EX.
REQ-007 SHALL have port flags, input, 4, meaning NZCV (used only under REQ-027).
REQ-008 SHALL have outputs ex_alu_op (4), ex_shift_imm, ex_load, ex_rf_en and ex_b_instr (1 each), giving the EX-stage control.
REQ-009 SHALL have outputs mem_rw (1), mem_data_size (2), mem_load (1), mem_rf_en (1) and mem_rd (RD_W), giving the MEM-stage control.
REQ-010 SHALL have outputs wb_rf_en (1) and wb_rd (RD_W), giving the WB-stage control.
REQ-011 SHALL have output stall, 1, meaning hold PC and the IF/ID register this cycle.

Function
REQ-012 SHALL decode combinationally from instruction as follows.
- dp = [27:26]==00.
- ls = [27:26]==01.
- br = [27:25]==101.
- load = ls & [20].
- store = ls & ~[20].
REQ-013 SHALL produce the following ID control.
- alu_op = [24:21].
- shift_imm = [25].
- b_instr = br.
- rd = [15:12].
- rw = ~store (1=read).
- data_size = {1'b0,[22]} for ls, else 00.
REQ-014 SHALL set rf_en = (dp & opcode not in 1000..1011) | load | (br & [24]); for br&[24], rd SHALL be forced to 14.
REQ-015 SHALL move ID control into EX, EX into MEM and MEM into WB on every clock edge; latency ID->EX, ->MEM and ->WB SHALL be 1, 2 and 3 cycles.
REQ-016 SHALL define a bubble as all control fields 0 and rd 0.
REQ-017 SHALL detect a hazard when ex_load & ex_rf_en and ex rd equals instruction[19:16] or, when store or (dp & ~[25]), instruction[3:0].
REQ-018 SHALL, on a hazard from IDLE, assert stall, inject a bubble into EX, load the bubble counter with LOAD_USE_BUBBLES-1 and enter STALL if that value is nonzero, else stay IDLE.
REQ-019 SHALL, in STALL, keep stall=1, inject a bubble each cycle and decrement the counter, returning to IDLE after the cycle in which the counter is 0.
REQ-020 SHALL make stall a combinational function of state, counter and the REQ-017 term.
REQ-021 SHALL, when flush=1, inject a bubble into EX, clear stall and return to IDLE with counter 0; flush SHALL take priority over hazard and stall.
REQ-022 SHALL never hold the MEM and WB stages under stall; they SHALL always advance.

Reset
REQ-023 SHALL, while reset_n=0, immediately clear all EX/MEM/WB control outputs and rd fields to 0.
REQ-024 SHALL, on reset, set mem_rw to 1, state to IDLE and the counter to 0; stall SHALL be 0 regardless of instruction.
REQ-025 SHALL discard in-flight stalls on reset asserted mid-stall; the first edge after release SHALL load the decoded ID.

Configuration
REQ-026 SHALL provide macro PCU_COND_EXEC_EN.
REQ-027 SHALL, with PCU_COND_EXEC_EN defined, evaluate instruction[31:28] against flags (EQ..AL, NV=never); a failing condition SHALL enter EX as a bubble.
REQ-028 SHALL, without PCU_COND_EXEC_EN, ignore the condition field and flags, treating every instruction as executed.

Verification
REQ-029 SHALL cover: reset_n=0 mid-stream -> all outputs 0 except mem_rw=1 and stall=0, asynchronously before the next clk.
REQ-030 SHALL cover: 0xE0812003 (ADD r2,r1,r3) -> next cycle ex_alu_op=0100, ex_rf_en=1; two cycles later wb_rf_en=1, wb_rd=2.
REQ-031 SHALL cover: 0xE5912000 (LDR r2,[r1]) followed by 0xE0823003 with LOAD_USE_BUBBLES=1 -> stall=1 for one cycle, one bubble in EX, ADD in EX the following cycle.
REQ-032 SHALL cover: same sequence with LOAD_USE_BUBBLES=3 -> stall held 3 cycles, 3 consecutive EX bubbles.
REQ-033 SHALL cover: flush=1 during the second stall cycle -> stall=0 that cycle, EX bubble, state IDLE.
REQ-034 SHALL cover: 0x05C12000 (STRBEQ) with flags Z=0 -> bubble with the macro defined; without it mem_rw=0, mem_data_size=01.
